mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16: max cycles a granted access waits for mem_ack before it is aborted.
REQ-002 Parameter STARVE_LIMIT, default 4: consecutive data grants allowed while a fetch waits.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 if_req  in  1  fetch request; held with if_addr stable until if_ready.
REQ-006 if_addr  in  32  fetch byte address (pc).
REQ-007 if_rdata  out  32  fetched instruction, registered.
REQ-008 if_ready  out  1  one-cycle pulse: fetch complete, if_rdata valid.
REQ-009 d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_ready.
REQ-010 d_we  in  1  1 = store, 0 = load.
REQ-011 d_addr  in  32  data byte address (alu_outM).
REQ-012 d_wdata  in  32  store data (write_data).
REQ-013 d_rdata  out  32  load data, registered.
REQ-014 d_ready  out  1  one-cycle pulse: data access complete.
REQ-015 mem_req  out  1  request to the single shared memory port.
REQ-016 mem_we  out  1  write enable to memory.
REQ-017 mem_addr  out  32  memory address.
REQ-018 mem_wdata  out  32  memory write data.
REQ-019 mem_rdata  in  32  memory read data, valid when mem_ack=1.
REQ-020 mem_ack  in  1  memory completion, sampled on clk edge.
REQ-021 stall  out  1  pipeline freeze to core.
REQ-022 err  out  1  one-cycle pulse on timeout abort.

Function
REQ-023 FSM states IDLE, FETCH, DATA; exactly one access outstanding at a time.
REQ-024 IDLE: d_req valid and (if_req invalid or starve_cnt<STARVE_LIMIT) -> DATA; else if_req valid -> FETCH; else stay.
REQ-025 A request is valid only if its ready output is 0 in that cycle (req is ignored in the cycle its ready pulses).
REQ-026 starve_cnt: +1 on each DATA grant while if_req valid, cleared on FETCH grant, saturates at STARVE_LIMIT.
REQ-027 In FETCH: mem_req=1, mem_we=0, mem_addr=if_addr, mem_wdata=0.
REQ-028 In DATA: mem_req=1, mem_we=d_we, mem_addr=d_addr, mem_wdata=d_wdata.
REQ-029 In IDLE: mem_req=0, mem_we=0; mem_addr, mem_wdata = 0.
REQ-030 FETCH with mem_ack=1: if_rdata<=mem_rdata, if_ready<=1 next cycle, -> IDLE.
REQ-031 DATA with mem_ack=1: d_rdata<=mem_rdata if d_we=0 (unchanged if store), d_ready<=1, -> IDLE.
REQ-032 Minimum latency request-seen to ready pulse: 2 cycles (grant edge, ack edge).
REQ-033 wait_cnt clears on grant, increments each cycle in FETCH/DATA without ack; at wait_cnt=TIMEOUT-1 without ack: ready pulses, rdata<=32'h0 (loads/fetches only), err pulses, -> IDLE.
REQ-034 mem_ack in IDLE is ignored.
REQ-035 mem_ack and timeout in same cycle: ack wins, err=0.
REQ-036 stall = (if_req & ~if_ready) | (d_req & ~d_ready), combinational.
REQ-037 if_ready, d_ready, err never high for more than one consecutive cycle per access.

Reset
REQ-038 rst=1 forces immediately: state IDLE, mem_req=0, mem_we=0, if_ready=d_ready=err=0, if_rdata=d_rdata=0, starve_cnt=wait_cnt=0.
REQ-039 Reset mid-access aborts it silently: no ready, no err after release; requester must re-request.

Verification
REQ-040 Lone fetch, if_addr=0x00000040, ack 1 cycle after grant with mem_rdata=0x8C220004 -> if_ready pulse at cycle 2, if_rdata=0x8C220004, stall high cycles 0-1.
REQ-041 if_req and d_req (load 0x100) together -> DATA granted first, FETCH granted after d_ready; mem_addr 0x100 then pc.
REQ-042 Fetch waiting, 5 back-to-back stores -> FETCH granted after 4th DATA grant (STARVE_LIMIT=4).
REQ-043 Load with mem_ack never asserted -> at 16th cycle in DATA: d_ready=1, err=1, d_rdata=0, state IDLE.
REQ-044 rst asserted during DATA -> mem_req low same cycle, all outputs 0, no d_ready after release.
REQ-045 Store 0xCAFEF00D to 0x200 -> mem_we=1, mem_wdata=0xCAFEF00D during DATA, d_rdata unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates one shared memory port between instruction fetch and data access.
// Data normally wins; a waiting fetch is protected by a starvation counter and every access by a timeout.
module mem_arbiter #(
    parameter int unsigned TIMEOUT      = 16,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic        err
);

    localparam int unsigned WAIT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } arbState_t;

    arbState_t             state;
    arbState_t             nextState;
    logic [WAIT_W-1:0]     waitCnt;
    logic [WAIT_W-1:0]     nextWait;
    logic [STARVE_W-1:0]   starveCnt;
    logic [STARVE_W-1:0]   nextStarve;
    logic [31:0]           nextIfRdata;
    logic [31:0]           nextDRdata;
    logic                  nextIfReady;
    logic                  nextDReady;
    logic                  nextErr;
    logic                  nextMemReq;
    logic                  nextMemWe;
    logic [31:0]           nextMemAddr;
    logic [31:0]           nextMemWdata;
    logic                  ifValid;
    logic                  dValid;
    logic                  timedOut;
    logic                  starveOk;

    // A request is ignored in the cycle its own ready pulses.
    assign ifValid  = if_req & ~if_ready;
    assign dValid   = d_req & ~d_ready;
    assign timedOut = (waitCnt == WAIT_W'(TIMEOUT - 1));
    assign starveOk = (starveCnt < STARVE_W'(STARVE_LIMIT));

    assign stall = (if_req & ~if_ready) | (d_req & ~d_ready);

    // Next-state and next registered-output logic.
    always_comb begin
        nextState    = state;
        nextWait     = waitCnt;
        nextStarve   = starveCnt;
        nextIfRdata  = if_rdata;
        nextDRdata   = d_rdata;
        nextIfReady  = 1'b0;
        nextDReady   = 1'b0;
        nextErr      = 1'b0;
        nextMemReq   = mem_req;
        nextMemWe    = mem_we;
        nextMemAddr  = mem_addr;
        nextMemWdata = mem_wdata;

        case (state)
            IDLE: begin
                if (dValid && (!ifValid || starveOk)) begin
                    nextState    = DATA;
                    nextWait     = '0;
                    nextMemReq   = 1'b1;
                    nextMemWe    = d_we;
                    nextMemAddr  = d_addr;
                    nextMemWdata = d_wdata;
                    if (ifValid) begin
                        nextStarve = starveCnt + STARVE_W'(1);
                    end
                end else if (ifValid) begin
                    nextState    = FETCH;
                    nextWait     = '0;
                    nextStarve   = '0;
                    nextMemReq   = 1'b1;
                    nextMemWe    = 1'b0;
                    nextMemAddr  = if_addr;
                    nextMemWdata = '0;
                end
            end

            FETCH, DATA: begin
                if (mem_ack || timedOut) begin
                    // Ack has priority over a coincident timeout.
                    nextState    = IDLE;
                    nextErr      = ~mem_ack;
                    nextMemReq   = 1'b0;
                    nextMemWe    = 1'b0;
                    nextMemAddr  = '0;
                    nextMemWdata = '0;
                    if (state == FETCH) begin
                        nextIfReady = 1'b1;
                        nextIfRdata = mem_ack ? mem_rdata : 32'h0;
                    end else begin
                        nextDReady = 1'b1;
                        if (!mem_we) begin
                            nextDRdata = mem_ack ? mem_rdata : 32'h0;
                        end
                    end
                end else begin
                    nextWait = waitCnt + WAIT_W'(1);
                end
            end

            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            waitCnt   <= '0;
            starveCnt <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
            err       <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= nextState;
            waitCnt   <= nextWait;
            starveCnt <= nextStarve;
            if_rdata  <= nextIfRdata;
            d_rdata   <= nextDRdata;
            if_ready  <= nextIfReady;
            d_ready   <= nextDReady;
            err       <= nextErr;
            mem_req   <= nextMemReq;
            mem_we    <= nextMemWe;
            mem_addr  <= nextMemAddr;
            mem_wdata <= nextMemWdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by randomized
// requesters and memory, all checked against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int TIMEOUT      = 16;
    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic        err;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Reference model: who owns the port (0 none, 1 fetch, 2 data), how long it has waited.
    int          mOwner;
    int          mAge;
    int          mStarve;
    logic [31:0] mIfRdata;
    logic [31:0] mDRdata;
    logic        mIfReady;
    logic        mDReady;
    logic        mErr;

    mem_arbiter #(.TIMEOUT(TIMEOUT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall(stall), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mOwner   = 0;
        mAge     = 0;
        mStarve  = 0;
        mIfRdata = '0;
        mDRdata  = '0;
        mIfReady = 1'b0;
        mDReady  = 1'b0;
        mErr     = 1'b0;
    endtask

    task automatic checkOutputs();
        chk("if_ready", 32'(if_ready), 32'(mIfReady));
        chk("d_ready",  32'(d_ready),  32'(mDReady));
        chk("err",      32'(err),      32'(mErr));
        chk("if_rdata", if_rdata, mIfRdata);
        chk("d_rdata",  d_rdata,  mDRdata);
        chk("mem_req",  32'(mem_req), 32'(mOwner != 0));
        chk("mem_we",   32'(mem_we),  32'((mOwner == 2) && d_we));
        chk("mem_addr", mem_addr, (mOwner == 1) ? if_addr : (mOwner == 2) ? d_addr : 32'h0);
        chk("mem_wdata", mem_wdata, (mOwner == 2) ? d_wdata : 32'h0);
    endtask

    // One clock cycle: predict from the inputs held across the edge, then compare.
    task automatic step();
        int          nOwner;
        int          nAge;
        int          nStarve;
        logic [31:0] nIf;
        logic [31:0] nD;
        logic        nIr;
        logic        nDr;
        logic        nE;
        bit          ifV;
        bit          dV;
        #1;
        ifV = if_req && !mIfReady;
        dV  = d_req && !mDReady;
        chk("stall", 32'(stall), 32'(ifV || dV));
        nOwner  = mOwner;
        nAge    = mAge;
        nStarve = mStarve;
        nIf     = mIfRdata;
        nD      = mDRdata;
        nIr     = 1'b0;
        nDr     = 1'b0;
        nE      = 1'b0;
        if (mOwner == 0) begin
            if (dV && (!ifV || mStarve < STARVE_LIMIT)) begin
                nOwner = 2;
                nAge   = 0;
                if (ifV) nStarve = (mStarve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : mStarve + 1;
            end else if (ifV) begin
                nOwner  = 1;
                nAge    = 0;
                nStarve = 0;
            end
        end else if (mem_ack || mAge == TIMEOUT - 1) begin
            nOwner = 0;
            nE     = !mem_ack;
            if (mOwner == 1) begin
                nIr = 1'b1;
                nIf = mem_ack ? mem_rdata : 32'h0;
            end else begin
                nDr = 1'b1;
                if (!d_we) nD = mem_ack ? mem_rdata : 32'h0;
            end
        end else begin
            nAge = mAge + 1;
        end
        @(posedge clk);
        #1;
        mOwner   = nOwner;
        mAge     = nAge;
        mStarve  = nStarve;
        mIfRdata = nIf;
        mDRdata  = nD;
        mIfReady = nIr;
        mDReady  = nDr;
        mErr     = nE;
        checkOutputs();
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic doReset();
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutputs();
        chk("rst_all_zero", 32'({if_ready, d_ready, err, mem_req, mem_we}), 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int cyc;
        int ackPct;
        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        modelReset();
        #1;
        checkOutputs();
        @(negedge clk);
        rst = 1'b0;

        // Lone fetch with ack one cycle after grant.
        if_req  = 1'b1;
        if_addr = 32'h0000_0040;
        step();
        chk("r040_grant_addr", mem_addr, 32'h0000_0040);
        chk("r040_stall_c1", 32'(stall), 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h8C22_0004;
        step();
        chk("r040_ready", 32'(if_ready), 32'd1);
        chk("r040_rdata", if_rdata, 32'h8C22_0004);
        chk("r040_stall_c2", 32'(stall), 32'd0);
        if_req  = 1'b0;
        mem_ack = 1'b0;
        step();

        // Simultaneous fetch and load: data first, then fetch.
        if_req  = 1'b1;
        if_addr = 32'h0000_0400;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h0000_0100;
        step();
        chk("r041_data_first", mem_addr, 32'h0000_0100);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        step();
        chk("r041_d_ready", 32'(d_ready), 32'd1);
        chk("r041_d_rdata", d_rdata, 32'h1234_5678);
        d_req   = 1'b0;
        mem_ack = 1'b0;
        step();
        chk("r041_fetch_next", mem_addr, 32'h0000_0400);
        mem_ack   = 1'b1;
        mem_rdata = 32'hA5A5_0001;
        step();
        chk("r041_if_ready", 32'(if_ready), 32'd1);
        if_req  = 1'b0;
        mem_ack = 1'b0;
        step();

        // Store leaves load data untouched.
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h0000_0200;
        d_wdata = 32'hCAFE_F00D;
        step();
        chk("r045_mem_we", 32'(mem_we), 32'd1);
        chk("r045_wdata", mem_wdata, 32'hCAFE_F00D);
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        step();
        chk("r045_d_ready", 32'(d_ready), 32'd1);
        chk("r045_rdata_kept", d_rdata, 32'h1234_5678);
        d_req   = 1'b0;
        mem_ack = 1'b0;
        step();

        // Load with no ack times out after TIMEOUT cycles in DATA.
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h0000_0300;
        step();
        cyc = 0;
        for (int i = 0; i < 40 && !d_ready; i++) begin
            if (mem_req) cyc++;
            step();
        end
        chk("r043_data_cycles", 32'(cyc), 32'(TIMEOUT));
        chk("r043_d_ready", 32'(d_ready), 32'd1);
        chk("r043_err", 32'(err), 32'd1);
        chk("r043_rdata_zero", d_rdata, 32'h0);
        d_req = 1'b0;
        step();
        chk("r043_err_one_cycle", 32'(err), 32'd0);

        // Reset during a data access aborts it without a ready.
        d_req  = 1'b1;
        d_addr = 32'h0000_0500;
        step();
        chk("r044_in_data", 32'(mem_req), 32'd1);
        d_req = 1'b0;
        doReset();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("r044_no_ready", 32'(d_ready), 32'd0);
        end

        // Randomized requesters and memory; later phase starves acks to force timeouts.
        for (int c = 0; c < 2000; c++) begin
            ackPct = (c < 1200) ? 40 : 4;
            if (!if_req) begin
                if ($urandom_range(0, 3) == 0) begin
                    if_req  = 1'b1;
                    if_addr = $urandom;
                end
            end else if (if_ready) begin
                if ($urandom_range(0, 1) == 0) if_req = 1'b0;
                else if_addr = $urandom;
            end
            if (!d_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    d_req   = 1'b1;
                    d_we    = 1'($urandom_range(0, 1));
                    d_addr  = $urandom;
                    d_wdata = $urandom;
                end
            end else if (d_ready) begin
                if ($urandom_range(0, 1) == 0) d_req = 1'b0;
                else begin
                    d_we    = 1'($urandom_range(0, 1));
                    d_addr  = $urandom;
                    d_wdata = $urandom;
                end
            end
            mem_ack   = ($urandom_range(0, 99) < ackPct);
            mem_rdata = $urandom;
            step();
            if (c == 1000) doReset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
